// File: rtl/lut_neuron_cfg_loader.sv
// -----------------------------------------------------------------------------
// lut_neuron_cfg_loader
//
// Runtime-programmable LUT neuron. A truth table arrives as a stream of
// configuration words and is written into an internal DEPTH x OUT_BITS table.
// Once a complete image has been loaded, the block serves registered lookups
// addressed by the neuron's input code.
//
// Word k, bit j of the stream lands on flat table bit k*WORD_W + j.
// Entry a occupies flat bits [a*OUT_BITS +: OUT_BITS]. Any bits of the last
// word that fall beyond the table are ignored.
//
// Ports:
//   clk         sole clock
//   rst         synchronous, active-high reset
//   cfg_valid   config word present
//   cfg_ready   loader accepts word (high whenever rst is low)
//   cfg_data    config word
//   cfg_last    marks the final word of a table image
//   cfg_err     sticky framing error (short image or missing last)
//   programmed  table holds a complete image; lookups enabled
//   in_valid    lookup request
//   in_ready    lookup accepted (same as programmed)
//   in_data     lookup address
//   out_valid   lookup result valid, one cycle after acceptance
//   out_data    table entry; holds its value while out_valid is low
// -----------------------------------------------------------------------------
module lut_neuron_cfg_loader #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  output logic                cfg_err,
  output logic                programmed,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int DEPTH = 1 << IN_BITS;
  localparam int TOTAL = DEPTH * OUT_BITS;
  localparam int WORDS = (TOTAL + WORD_W - 1) / WORD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    ARMED
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [OUT_BITS-1:0]   tbl [DEPTH];

  logic cfg_fire;
  logic lookup_fire;

  assign cfg_ready   = !rst;
  assign programmed  = (state == ARMED);
  assign in_ready    = programmed;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign lookup_fire = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      cnt       <= '0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      // NOTE: the table is reset on purpose: a reset must leave no stale
      // entries behind, so this storage is flops rather than a RAM macro.
      for (int a = 0; a < DEPTH; a++) begin
        tbl[a] <= '0;
      end
    end else begin
      // Lookup reads the table as it stood before this edge, so a config
      // word accepted on the same edge cannot affect the returned entry.
      // NOTE: non-blocking assignments are what give that read-old-value
      // behaviour; a blocking write to tbl above this read would break it.
      if (lookup_fire) begin
        out_valid <= 1'b1;
        out_data  <= tbl[in_data];
      end else begin
        out_valid <= 1'b0;
      end

      if (cfg_fire) begin
        // Scatter the word into the entries whose flat bits fall in slot cnt;
        // bits past TOTAL in the last word have no destination.
        for (int a = 0; a < DEPTH; a++) begin
          for (int b = 0; b < OUT_BITS; b++) begin
            if ((a * OUT_BITS + b) / WORD_W == int'(cnt)) begin
              tbl[a][b] <= cfg_data[(a * OUT_BITS + b) % WORD_W];
            end
          end
        end

        // A new image clears the error; a framing error on this same word
        // overrides the clear below.
        if (cnt == '0) begin
          cfg_err <= 1'b0;
        end

        if (cnt == LAST_CNT) begin
          cnt <= '0;
          if (cfg_last) begin
            state <= ARMED;
          end else begin
            cfg_err <= 1'b1;
            state   <= EMPTY;
          end
        end else if (cfg_last) begin
          // Short image: partial contents stay in the table but are unusable.
          cfg_err <= 1'b1;
          cnt     <= '0;
          state   <= EMPTY;
        end else begin
          cnt   <= cnt + 1'b1;
          state <= LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_lut_neuron_cfg_loader
//
// Directed bench for lut_neuron_cfg_loader with default parameters
// (64 x 1 table, 8-bit config words, 8 words per image). Inputs change 1 ns
// after a rising edge; outputs are sampled at the same point, i.e. they show
// the effect of the edge just taken.
// -----------------------------------------------------------------------------
module tb_lut_neuron_cfg_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       cfg_err;
  logic       programmed;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic [0:0] out_data;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  lut_neuron_cfg_loader #(
    .IN_BITS (6),
    .OUT_BITS(1),
    .WORD_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_err   (cfg_err),
    .programmed(programmed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send n back-to-back words of value val, numbered from first; cfg_last is
  // raised on word number last_at (use -1 for never).
  task automatic load(input logic [7:0] val, input int first, input int n, input int last_at);
    for (int i = first; i < first + n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = val;
      cfg_last  = (i == last_at);
      step();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [5:0] addr, input logic exp);
    in_valid = 1'b1;
    in_data  = addr;
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_programmed"}, programmed, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;

    // ---- reset state ----
    step();
    step();
    check("rst_cfg_ready_low", cfg_ready, 0);
    check_reset_outputs("rst");
    rst = 1'b0;
    #1;
    check("cfg_ready_high", cfg_ready, 1);

    // ---- full 0xAA load ----
    load(8'hAA, 0, 7, 7);
    check("aa_not_yet_programmed", programmed, 0);
    load(8'hAA, 7, 1, 7);
    check("aa_programmed", programmed, 1);
    check("aa_in_ready", in_ready, 1);
    check("aa_cfg_err", cfg_err, 0);
    lookup("aa_lk0", 6'd0, 1'b0);
    lookup("aa_lk1", 6'd1, 1'b1);
    lookup("aa_lk62", 6'd62, 1'b0);
    lookup("aa_lk63", 6'd63, 1'b1);
    step();
    check("idle_out_valid", out_valid, 0);
    check("idle_out_data_hold", out_data, 1);

    // ---- streaming lookups 0..63 ----
    for (int a = 0; a < 64; a++) begin
      in_valid = 1'b1;
      in_data  = 6'(a);
      step();
      check($sformatf("stream%0d_valid", a), out_valid, 1);
      check($sformatf("stream%0d_data", a), out_data, 32'(a % 2));
    end
    in_valid = 1'b0;
    step();
    check("stream_end_valid", out_valid, 0);

    // ---- reprogram collision: lookup 1 with word 0 of a 0x00 image ----
    in_valid  = 1'b1;
    in_data   = 6'd1;
    cfg_valid = 1'b1;
    cfg_data  = 8'h00;
    cfg_last  = 1'b0;
    step();
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    check("coll_out_valid", out_valid, 1);
    check("coll_out_data_old", out_data, 1);
    check("coll_programmed", programmed, 0);
    check("coll_in_ready", in_ready, 0);
    // Lookup attempted mid-load must be refused.
    in_valid = 1'b1;
    in_data  = 6'd1;
    step();
    in_valid = 1'b0;
    check("coll_refused", out_valid, 0);
    load(8'h00, 1, 7, 7);
    check("coll_rearmed", programmed, 1);
    lookup("coll_lk1_new", 6'd1, 1'b0);

    // ---- short image: cfg_last on word 3 ----
    load(8'h55, 0, 4, 3);
    check("short_err", cfg_err, 1);
    check("short_programmed", programmed, 0);
    check("short_in_ready", in_ready, 0);
    load(8'hFF, 0, 1, 7);
    check("short_err_cleared", cfg_err, 0);
    load(8'hFF, 1, 7, 7);
    check("ff_programmed", programmed, 1);
    lookup("ff_lk37", 6'd37, 1'b1);

    // ---- missing last ----
    load(8'hAA, 0, 8, -1);
    check("nolast_err", cfg_err, 1);
    check("nolast_programmed", programmed, 0);
    in_valid = 1'b1;
    in_data  = 6'd5;
    step();
    in_valid = 1'b0;
    check("nolast_lookup_refused", out_valid, 0);

    // ---- reset mid-load ----
    load(8'h33, 0, 5, -1);
    rst = 1'b1;
    step();
    check("midrst_cfg_ready_low", cfg_ready, 0);
    check_reset_outputs("midrst");
    rst = 1'b0;
    load(8'h0F, 0, 8, 7);
    check("0f_programmed", programmed, 1);
    check("0f_cfg_err", cfg_err, 0);
    lookup("0f_lk3", 6'd3, 1'b1);
    lookup("0f_lk4", 6'd4, 1'b0);

    // ---- reset drops an in-flight lookup ----
    in_valid = 1'b1;
    in_data  = 6'd3;
    rst      = 1'b1;
    step();
    in_valid = 1'b0;
    rst      = 1'b0;
    check_reset_outputs("rst_inflight");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
